// File: rtl/alu_pkg.sv
// Shared widths, state encoding and operand payload for the ALU request arbiter.
package alu_pkg;

    localparam int unsigned DATA_W          = 8;
    localparam int unsigned MODE_W          = 3;
    localparam int unsigned ALU_LAT_DEFAULT = 1;
    localparam int unsigned LAT_CNT_W       = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [MODE_W-1:0] mode;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } alu_op_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant; the pointer favours whichever requester was not granted last.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       advance,
    output logic [1:0] grant
);

    logic favor1;

    always_comb begin
        grant = 2'b00;
        if (favor1) begin
            grant[1] = valid[1];
            grant[0] = valid[0] & ~valid[1];
        end else begin
            grant[0] = valid[0];
            grant[1] = valid[1] & ~valid[0];
        end
    end

    // After granting req0, favour req1 next, and vice versa.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            favor1 <= 1'b0;
        end else if (advance) begin
            favor1 <= grant[0];
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two requesters onto one shared ALU with fixed latency ALU_LAT and
// returns the captured result to the owner as a one-cycle strobe.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LAT = ALU_LAT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [MODE_W-1:0] req0_mode,
    input  logic [DATA_W-1:0] req0_a,
    input  logic [DATA_W-1:0] req0_b,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [MODE_W-1:0] req1_mode,
    input  logic [DATA_W-1:0] req1_a,
    input  logic [DATA_W-1:0] req1_b,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_fz,
    output logic              rsp_fc,
    output logic              alu_en,
    output logic [MODE_W-1:0] alu_mode,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    input  logic [DATA_W-1:0] alu_sum,
    input  logic              alu_fz,
    input  logic              alu_fc,
    output logic              busy
);

    state_e               state;
    state_e               state_d;
    logic [LAT_CNT_W-1:0] wait_cnt;
    logic [LAT_CNT_W-1:0] wait_cnt_d;
    logic [1:0]           grant;
    logic                 accept;
    logic                 owner_q;
    alu_op_t              op_q;
    alu_op_t              op_d;

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst     (rst),
        .valid   ({req1_valid, req0_valid}),
        .advance (accept),
        .grant   (grant)
    );

    // Ready is a pure decode so a request is accepted in the same cycle it is seen.
    assign accept     = ~rst & (state == ST_IDLE) & (|grant);
    assign req0_ready = accept & grant[0];
    assign req1_ready = accept & grant[1];

    assign op_d     = grant[1] ? '{mode: req1_mode, a: req1_a, b: req1_b}
                               : '{mode: req0_mode, a: req0_a, b: req0_b};
    assign alu_mode = op_q.mode;
    assign alu_a    = op_q.a;
    assign alu_b    = op_q.b;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            wait_cnt <= '0;
        end else begin
            state    <= state_d;
            wait_cnt <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state;
        wait_cnt_d = wait_cnt;
        case (state)
            ST_IDLE: begin
                if (accept) state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
            end
            ST_WAIT: begin
                if (wait_cnt == LAT_CNT_W'(ALU_LAT - 1)) begin
                    state_d = ST_RESP;
                end else begin
                    wait_cnt_d = wait_cnt + LAT_CNT_W'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Operand latch, ALU strobe, result capture and owner strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q       <= '0;
            owner_q    <= 1'b0;
            alu_en     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp_data   <= '0;
            rsp_fz     <= 1'b0;
            rsp_fc     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            alu_en     <= accept;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            busy       <= (state_d != ST_IDLE);
            if (accept) begin
                op_q    <= op_d;
                owner_q <= grant[1];
            end
            if ((state == ST_WAIT) && (state_d == ST_RESP)) begin
                rsp_data   <= alu_sum;
                rsp_fz     <= alu_fz;
                rsp_fc     <= alu_fc;
                rsp0_valid <= ~owner_q;
                rsp1_valid <= owner_q;
            end
        end
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter ALU_LAT, default 1, meaning cycles from the alu_en sampling edge to a valid alu_sum/alu_fz/alu_fc (legal 1..7).
REQ-002 SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-003 SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports reqN_valid  in  1  request from requester N (N=0,1).
REQ-005 SHALL have ports reqN_mode  in  3, reqN_a  in  8, reqN_b  in  8  operation code and operands for requester N.
REQ-006 SHALL have ports reqN_ready  out  1  request accepted this cycle.
REQ-007 SHALL have ports rspN_valid  out  1  one-cycle result strobe for requester N.
REQ-008 SHALL have ports rsp_data  out  8, rsp_fz  out  1, rsp_fc  out  1  shared result and flags.
REQ-009 SHALL have ports alu_en  out  1, alu_mode  out  3, alu_a  out  8, alu_b  out  8  drive to the shared ALU.
REQ-010 SHALL have ports alu_sum  in  8, alu_fz  in  1, alu_fc  in  1  ALU result and flags.
REQ-011 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-012 SHALL implement a four-state FSM: IDLE, ISSUE, WAIT, RESP.
REQ-013 SHALL accept requests in IDLE only; reqN_ready is combinational from reqN_valid and the priority pointer; at most one ready is high per cycle.
REQ-014 SHALL treat handshake as reqN_valid and reqN_ready high at the same rising edge; it latches mode/a/b and the owner id, then IDLE->ISSUE.
REQ-015 SHALL resolve both-valid in IDLE by round robin: grant the requester not granted last; the pointer updates on each handshake.
REQ-016 SHALL, in ISSUE, assert alu_en for exactly one cycle with the latched operands; ISSUE->WAIT.
REQ-017 SHALL hold alu_mode/alu_a/alu_b stable from ISSUE through WAIT, with alu_en low in WAIT.
REQ-018 SHALL remain in WAIT exactly ALU_LAT cycles; at the edge leaving WAIT it captures alu_sum/alu_fz/alu_fc into rsp_data/rsp_fz/rsp_fc; WAIT->RESP.
REQ-019 SHALL, in RESP, pulse rsp_valid for the owner for one cycle; RESP->IDLE; no backpressure on responses.
REQ-020 SHALL hold rsp_data/rsp_fz/rsp_fc until the next capture.
REQ-021 SHALL pass all 8 mode codes to the ALU unmodified; no arithmetic inside this block.
REQ-022 SHALL give latency, for handshake at edge T: alu_en high in cycle T+1, rsp_valid in cycle T+2+ALU_LAT; throughput one operation per 3+ALU_LAT cycles.
REQ-023 SHALL ignore reqN_valid deasserted before a handshake, with no state change.

Reset
REQ-024 SHALL, on rst high, immediately force IDLE, all outputs 0, operand and result registers 0, and the pointer favouring req0; an in-flight operation produces no response.

Structure
REQ-025 SHALL place the data width (8), mode width (3), state encodings and the ALU_LAT default in shared package alu_pkg.
REQ-026 SHALL implement the two-way round-robin grant as sub-module rr_arb2 (inputs valid[1:0], advance; output grant[1:0]).

Verification
REQ-027 SHALL check: req0 only, mode 000, a=5, b=13 -> req0_ready high at T; alu_en at T+1 with a=5, b=13; rsp0_valid at T+3 with rsp_data=0x12, fz=0, fc=0.
REQ-028 SHALL check: both valid from reset with different operands -> req0 granted first, then req1 in the next IDLE; rsp0_valid precedes rsp1_valid.
REQ-029 SHALL check: both held valid for 4 operations -> grants alternate 0,1,0,1 and one rsp_valid per operation.
REQ-030 SHALL check: a=0xFF, b=0x01, mode 000 -> rsp_data=0x00, rsp_fz=1, rsp_fc=1, taken from the ALU.
REQ-031 SHALL check: rst asserted mid-WAIT -> all outputs 0 asynchronously and no rsp_valid; after release, a req1-only request is served normally.
REQ-032 SHALL check: req1 valid while req0 is in flight -> req1_ready stays 0 until IDLE, and alu_a/alu_b stay unchanged through WAIT; run with ALU_LAT=3 to confirm rsp_valid at T+5.
